// File: rtl/pifo_pkg.sv
//------------------------------------------------------------------------------
// Module   : pifo_pkg
// Brief    : Shared types and defaults for the 4-ary PIFO tree engines.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pifo_pkg;

    localparam int unsigned DEF_PTW = 16;
    localparam int unsigned DEF_MTW = 0;
    localparam int unsigned DEF_CTW = 10;
    localparam int unsigned DEF_VW  = DEF_MTW + DEF_PTW;

    localparam logic [DEF_PTW-1:0] PRIO_EMPTY = '1;

    // val carries {meta,prio}; meta may be zero-width so it is folded into val
    typedef struct packed {
        logic [DEF_CTW-1:0] cnt;
        logic [DEF_VW-1:0]  val;
    } slot_t;

    typedef slot_t [3:0] node_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        TAIL = 2'd2
    } pop_state_e;

endpackage

`default_nettype wire

// File: rtl/pifo_min4_sel.sv
//------------------------------------------------------------------------------
// Module   : pifo_min4_sel
// Brief    : 4-way minimum priority select; skips cnt==0 slots, lowest index wins ties.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pifo_min4_sel
    import pifo_pkg::*;
#(
    parameter int unsigned PTW = DEF_PTW,
    parameter int unsigned CTW = DEF_CTW
) (
    input  logic [4*CTW-1:0] cnt_i,
    input  logic [4*PTW-1:0] prio_i,
    output logic [1:0]       idx_o,
    output logic             all_empty_o
);

    logic [PTW-1:0] best;

    always_comb begin
        idx_o       = 2'd0;
        all_empty_o = 1'b1;
        best        = '1;
        for (int i = 0; i < 4; i++) begin
            if (cnt_i[i*CTW +: CTW] != '0) begin
                // strict compare keeps the earlier slot on ties
                if (all_empty_o || (prio_i[i*PTW +: PTW] < best)) begin
                    idx_o       = 2'(i);
                    best        = prio_i[i*PTW +: PTW];
                    all_empty_o = 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pop_rpu.sv
//------------------------------------------------------------------------------
// Module   : pop_rpu
// Brief    : Pop engine for the SRAM-backed 4-ary PIFO tree. Optional statistics
//            counters are enabled with the POP_RPU_STATS_EN macro.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pop_rpu
    import pifo_pkg::*;
#(
    parameter int unsigned PTW   = DEF_PTW,
    parameter int unsigned MTW   = DEF_MTW,
    parameter int unsigned CTW   = DEF_CTW,
    parameter int unsigned ADW   = 20,
    parameter int unsigned LEVEL = 8
) (
    input  logic                             i_clk,
    input  logic                             i_arst_n,
    output logic                             ready,
    input  logic                             i_pop,
    output logic                             o_pop_valid,
    output logic [MTW+PTW-1:0]               o_pop_data,
    output logic                             o_pop_underflow,
    output logic                             o_read,
    input  logic [4*(CTW+MTW+PTW)-1:0]       i_read_data,
    output logic                             o_write,
    output logic [4*(CTW+MTW+PTW)-1:0]       o_write_data,
    output logic [$clog2(LEVEL)-1:0]         o_read_level,
    output logic [$clog2(LEVEL)-1:0]         o_write_level,
    output logic [ADW-1:0]                   o_read_addr,
    output logic [ADW-1:0]                   o_write_addr
`ifdef POP_RPU_STATS_EN
    ,
    output logic [31:0]                      o_pop_cnt,
    output logic [15:0]                      o_uflow_cnt
`endif
);

    localparam int unsigned VW = MTW + PTW;
    localparam int unsigned SW = CTW + VW;
    localparam int unsigned NW = 4 * SW;
    localparam int unsigned LW = $clog2(LEVEL);

    pop_state_e    state_q, state_d;
    logic [LW-1:0]  lvl_q, lvl_d;
    logic [ADW-1:0] addr_q, addr_d;
    logic [NW-1:0]  node_q, node_d;
    logic [1:0]     slot_q, slot_d;
    logic           valid_q, valid_d;
    logic [VW-1:0]  data_q, data_d;
    logic           uflow_q, uflow_d;
    logic           byp_q, byp_d;
    logic [NW-1:0]  byp_data_q;

    logic [NW-1:0]    w_node;
    logic [4*CTW-1:0] w_cnts;
    logic [4*PTW-1:0] w_prios;
    logic [1:0]       w_m;
    logic             w_empty;
    logic [CTW-1:0]   w_cnt_m;
    logic [VW-1:0]    w_val_m;
    logic [1:0]       w_pm;
    logic [CTW-1:0]   w_parent_cnt;

    // The SRAM returns pre-write data on a same-address collision, so the last write wins
    assign w_node = byp_q ? byp_data_q : i_read_data;

    for (genvar g = 0; g < 4; g++) begin : g_slot
        assign w_cnts[g*CTW +: CTW]  = w_node[g*SW+VW +: CTW];
        assign w_prios[g*PTW +: PTW] = w_node[g*SW +: PTW];
    end

    pifo_min4_sel #(
        .PTW (PTW),
        .CTW (CTW)
    ) u_sel (
        .cnt_i       (w_cnts),
        .prio_i      (w_prios),
        .idx_o       (w_m),
        .all_empty_o (w_empty)
    );

    assign w_cnt_m      = w_node[int'(w_m)*SW+VW +: CTW];
    assign w_val_m      = w_node[int'(w_m)*SW +: VW];
    assign w_pm         = addr_q[1:0];
    assign w_parent_cnt = node_q[int'(w_pm)*SW+VW +: CTW];

    always_comb begin
        state_d       = state_q;
        lvl_d         = lvl_q;
        addr_d        = addr_q;
        node_d        = node_q;
        slot_d        = slot_q;
        valid_d       = 1'b0;
        data_d        = data_q;
        uflow_d       = 1'b0;
        ready         = 1'b0;
        o_read        = 1'b0;
        o_read_level  = '0;
        o_read_addr   = '0;
        o_write       = 1'b0;
        o_write_level = '0;
        o_write_addr  = '0;
        o_write_data  = '0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (i_pop) begin
                    o_read  = 1'b1;
                    lvl_d   = '0;
                    addr_d  = '0;
                    state_d = WALK;
                end
            end
            WALK: begin
                if ((lvl_q == '0) && w_empty) begin
                    uflow_d = 1'b1;
                    ready   = 1'b1;
                    if (i_pop) begin
                        o_read = 1'b1;
                        lvl_d  = '0;
                        addr_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (lvl_q == '0) begin
                        valid_d = 1'b1;
                        data_d  = w_val_m;
                    end else begin
                        // The parent slot that led here sits in the low two address bits
                        o_write       = 1'b1;
                        o_write_level = lvl_q - 1'b1;
                        o_write_addr  = addr_q >> 2;
                        o_write_data  = node_q;
                        o_write_data[int'(w_pm)*SW +: SW] = {w_parent_cnt - 1'b1, w_val_m};
                    end
                    node_d = w_node;
                    slot_d = w_m;
                    if ((w_cnt_m == CTW'(1)) || (lvl_q == LW'(LEVEL-1))) begin
                        state_d = TAIL;
                    end else begin
                        o_read       = 1'b1;
                        o_read_level = lvl_q + 1'b1;
                        o_read_addr  = {addr_q[ADW-3:0], w_m};
                        lvl_d        = lvl_q + 1'b1;
                        addr_d       = {addr_q[ADW-3:0], w_m};
                    end
                end
            end
            TAIL: begin
                ready         = 1'b1;
                o_write       = 1'b1;
                o_write_level = lvl_q;
                o_write_addr  = addr_q;
                o_write_data  = node_q;
                o_write_data[int'(slot_q)*SW +: SW] = {{CTW{1'b0}}, {VW{1'b1}}};
                if (i_pop) begin
                    o_read  = 1'b1;
                    lvl_d   = '0;
                    addr_d  = '0;
                    state_d = WALK;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byp_d = o_read && o_write && (o_read_level == o_write_level)
                   && (o_read_addr == o_write_addr);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q    <= IDLE;
            lvl_q      <= '0;
            addr_q     <= '0;
            node_q     <= '0;
            slot_q     <= '0;
            valid_q    <= 1'b0;
            data_q     <= '1;
            uflow_q    <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            lvl_q      <= lvl_d;
            addr_q     <= addr_d;
            node_q     <= node_d;
            slot_q     <= slot_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            uflow_q    <= uflow_d;
            byp_q      <= byp_d;
            byp_data_q <= o_write_data;
        end
    end

    assign o_pop_valid     = valid_q;
    assign o_pop_data      = data_q;
    assign o_pop_underflow = uflow_q;

`ifdef POP_RPU_STATS_EN
    logic [31:0] pop_cnt_q;
    logic [15:0] uflow_cnt_q;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            pop_cnt_q   <= '0;
            uflow_cnt_q <= '0;
        end else begin
            if (valid_q && (pop_cnt_q != '1))
                pop_cnt_q <= pop_cnt_q + 32'd1;
            if (uflow_q && (uflow_cnt_q != '1))
                uflow_cnt_q <= uflow_cnt_q + 16'd1;
        end
    end

    assign o_pop_cnt   = pop_cnt_q;
    assign o_uflow_cnt = uflow_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pop_rpu.sv
//------------------------------------------------------------------------------
// Module   : tb_pop_rpu
// Brief    : Self-checking bench for pop_rpu with an SRAM model and sorted-queue reference.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_pop_rpu;
    import pifo_pkg::*;

    localparam int PTW   = 16;
    localparam int MTW   = 0;
    localparam int CTW   = 10;
    localparam int ADW   = 20;
    localparam int LEVEL = 8;
    localparam int LW    = $clog2(LEVEL);
    localparam int VW    = MTW + PTW;
    localparam int NW    = 4 * (CTW + VW);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_pop = 1'b0;
    logic          ready, pop_valid, pop_uflow, rd, wr;
    logic [VW-1:0] pop_data;
    logic [NW-1:0] rdata, wdata;
    logic [LW-1:0] rlvl, wlvl;
    logic [ADW-1:0] raddr, waddr;
`ifdef POP_RPU_STATS_EN
    logic [31:0]   pop_cnt;
    logic [15:0]   uflow_cnt;
`endif

    int    n_vec = 0;
    int    n_err = 0;
    node_t mem [int];
    int    got_q [$];
    int    wr_cnt = 0;
    int    last_wr_lvl = -1;
    int    uf_cnt = 0;

    always #5 clk = ~clk;

    pop_rpu #(.PTW(PTW), .MTW(MTW), .CTW(CTW), .ADW(ADW), .LEVEL(LEVEL)) dut (
        .i_clk           (clk),
        .i_arst_n        (rst_n),
        .ready           (ready),
        .i_pop           (i_pop),
        .o_pop_valid     (pop_valid),
        .o_pop_data      (pop_data),
        .o_pop_underflow (pop_uflow),
        .o_read          (rd),
        .i_read_data     (rdata),
        .o_write         (wr),
        .o_write_data    (wdata),
        .o_read_level    (rlvl),
        .o_write_level   (wlvl),
        .o_read_addr     (raddr),
        .o_write_addr    (waddr)
`ifdef POP_RPU_STATS_EN
        ,
        .o_pop_cnt       (pop_cnt),
        .o_uflow_cnt     (uflow_cnt)
`endif
    );

    function automatic int key(input int l, input int a);
        return l * (1 << ADW) + a;
    endfunction

    function automatic node_t empty_node();
        node_t n;
        for (int i = 0; i < 4; i++) begin
            n[i].cnt = '0;
            n[i].val = '1;
        end
        return n;
    endfunction

    function automatic node_t rd_mem(input int l, input int a);
        if (mem.exists(key(l, a))) return mem[key(l, a)];
        return empty_node();
    endfunction

    // SRAM: one-cycle read latency, read-during-write returns the old contents
    always @(posedge clk) begin
        if (rd) rdata <= rd_mem(int'(rlvl), int'(raddr));
        if (wr) mem[key(int'(wlvl), int'(waddr))] = wdata;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (pop_valid) got_q.push_back(int'(pop_data));
            if (pop_uflow) uf_cnt++;
            if (wr) begin
                wr_cnt++;
                last_wr_lvl = int'(wlvl);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_pop(output bit ok);
        wait_ready(ok);
        if (ok) begin
            i_pop = 1'b1;
            tick();
            i_pop = 1'b0;
            tick(12);
        end
    endtask

    // Software-style PIFO insert: fill an empty slot, else sink the larger value into the lightest sub-tree
    task automatic push_tree(input int v);
        int            l = 0;
        int            a = 0;
        int            s, e;
        logic [VW-1:0] cur, tmp;
        node_t         n;
        cur = VW'(v);
        while (1) begin
            if (l >= LEVEL) begin
                $display("FAIL push_depth: level %0d reached, limit %0d", l, LEVEL);
                $fatal(1);
            end
            n = rd_mem(l, a);
            e = -1;
            for (int i = 3; i >= 0; i--) if (n[i].cnt == '0) e = i;
            if (e >= 0) begin
                n[e].cnt = CTW'(1);
                n[e].val = cur;
                mem[key(l, a)] = n;
                return;
            end
            s = 0;
            for (int i = 1; i < 4; i++) if (n[i].cnt < n[s].cnt) s = i;
            if (cur < n[s].val) begin
                tmp = n[s].val;
                n[s].val = cur;
                cur = tmp;
            end
            n[s].cnt = n[s].cnt + 1'b1;
            mem[key(l, a)] = n;
            a = a * 4 + s;
            l++;
        end
    endtask

    task automatic build_chain();
        node_t n;
        mem.delete();
        for (int l = 0; l < LEVEL; l++) begin
            n = empty_node();
            n[0].cnt = CTW'(LEVEL - l);
            n[0].val = VW'(10 + l);
            mem[key(l, 0)] = n;
        end
    endtask

    task automatic test_reset();
        tick(2);
        n_vec++;
        if ({ready, pop_valid, pop_uflow, wr, rd} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 10000", {ready, pop_valid, pop_uflow, wr, rd});
        end
        n_vec++;
        if ({rlvl, wlvl, raddr, waddr} !== '0) begin
            n_err++;
            $display("FAIL reset_addr: got %h want 0", {rlvl, wlvl, raddr, waddr});
        end
        n_vec++;
        if (pop_data !== '1) begin
            n_err++;
            $display("FAIL reset_data: got %h want ffff", pop_data);
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_single();
        node_t n;
        bit    ok;
        mem.delete();
        got_q.delete();
        n = empty_node();
        n[0].cnt = CTW'(1);
        n[0].val = VW'(9);
        mem[key(0, 0)] = n;
        wait_ready(ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL single_timeout: ready never seen");
        end
        i_pop = 1'b1;
        tick();
        i_pop = 1'b0;
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL single_walk_ready: got %b want 0", ready);
        end
        tick();
        n_vec++;
        if (pop_valid !== 1'b1 || pop_data !== VW'(9)) begin
            n_err++;
            $display("FAIL single_data: got valid %b data %0d want valid 1 data 9", pop_valid, pop_data);
        end
        n_vec++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_tail_ready: got %b want 1", ready);
        end
        tick(3);
        n = rd_mem(0, 0);
        n_vec++;
        if (n[0].cnt !== '0 || n[0].val !== '1) begin
            n_err++;
            $display("FAIL single_root: got cnt %0d val %h want cnt 0 val ffff", n[0].cnt, n[0].val);
        end
    endtask

    task automatic test_refill();
        node_t n;
        bit    ok;
        mem.delete();
        got_q.delete();
        n = empty_node();
        n[2].cnt = CTW'(3);
        n[2].val = VW'(4);
        mem[key(0, 0)] = n;
        n = empty_node();
        n[0].cnt = CTW'(1);
        n[0].val = VW'(7);
        n[1].cnt = CTW'(1);
        n[1].val = VW'(5);
        mem[key(1, 2)] = n;
        do_pop(ok);
        n_vec++;
        if (!ok || got_q.size() != 1 || got_q[0] != 4) begin
            n_err++;
            $display("FAIL refill_data: got %0d pops first %0d want 1 pop of 4", got_q.size(),
                     got_q.size() > 0 ? got_q[0] : -1);
        end
        n = rd_mem(0, 2 - 2);
        n_vec++;
        if (n[2].cnt !== CTW'(2) || n[2].val !== VW'(5)) begin
            n_err++;
            $display("FAIL refill_root: got cnt %0d val %0d want cnt 2 val 5", n[2].cnt, n[2].val);
        end
        n = rd_mem(1, 2);
        n_vec++;
        if (n[1].cnt !== '0 || n[1].val !== '1 || n[0].cnt !== CTW'(1) || n[0].val !== VW'(7)) begin
            n_err++;
            $display("FAIL refill_child: got s1 %0d/%h s0 %0d/%0d want s1 0/ffff s0 1/7",
                     n[1].cnt, n[1].val, n[0].cnt, n[0].val);
        end
    endtask

    task automatic test_underflow();
        int w0, u0;
        bit ok;
        mem.delete();
        got_q.delete();
        w0 = wr_cnt;
        u0 = uf_cnt;
        do_pop(ok);
        n_vec++;
        if (!ok || uf_cnt - u0 != 1) begin
            n_err++;
            $display("FAIL uflow_pulse: got %0d pulses want 1", uf_cnt - u0);
        end
        n_vec++;
        if (got_q.size() != 0 || wr_cnt != w0) begin
            n_err++;
            $display("FAIL uflow_side: got %0d valids %0d writes want 0 and 0", got_q.size(), wr_cnt - w0);
        end
    endtask

    task automatic test_full_depth();
        node_t n;
        int    w0, lows;
        bit    ok;
        build_chain();
        got_q.delete();
        wait_ready(ok);
        i_pop = 1'b1;
        tick();
        i_pop = 1'b0;
        w0 = wr_cnt;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            if (ready) break;
            lows++;
            tick();
        end
        n_vec++;
        if (lows != LEVEL) begin
            n_err++;
            $display("FAIL depth_ready: got %0d busy cycles want %0d", lows, LEVEL);
        end
        tick(4);
        n_vec++;
        if (wr_cnt - w0 != LEVEL || last_wr_lvl != LEVEL - 1) begin
            n_err++;
            $display("FAIL depth_writes: got %0d writes last level %0d want %0d writes last level %0d",
                     wr_cnt - w0, last_wr_lvl, LEVEL, LEVEL - 1);
        end
        n_vec++;
        if (got_q.size() != 1 || got_q[0] != 10) begin
            n_err++;
            $display("FAIL depth_data: got %0d pops first %0d want 1 pop of 10", got_q.size(),
                     got_q.size() > 0 ? got_q[0] : -1);
        end
        n = rd_mem(0, 0);
        n_vec++;
        if (n[0].cnt !== CTW'(LEVEL - 1) || n[0].val !== VW'(11)) begin
            n_err++;
            $display("FAIL depth_root: got cnt %0d val %0d want cnt %0d val 11", n[0].cnt, n[0].val, LEVEL - 1);
        end
        n = rd_mem(LEVEL - 1, 0);
        n_vec++;
        if (n[0].cnt !== '0 || n[0].val !== '1) begin
            n_err++;
            $display("FAIL depth_leaf: got cnt %0d val %h want cnt 0 val ffff", n[0].cnt, n[0].val);
        end
    endtask

    task automatic test_back_to_back();
        node_t n;
        bit    ok;
        mem.delete();
        got_q.delete();
        n = empty_node();
        n[0].cnt = CTW'(1);
        n[0].val = VW'(3);
        n[1].cnt = CTW'(1);
        n[1].val = VW'(6);
        mem[key(0, 0)] = n;
        wait_ready(ok);
        i_pop = 1'b1;
        tick(2);
        n_vec++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_tail_ready: got %b want 1", ready);
        end
        tick();
        i_pop = 1'b0;
        tick(10);
        n_vec++;
        if (got_q.size() != 2 || got_q[0] != 3 || got_q[1] != 6) begin
            n_err++;
            $display("FAIL b2b_order: got %0d pops %0d,%0d want 2 pops 3,6", got_q.size(),
                     got_q.size() > 0 ? got_q[0] : -1, got_q.size() > 1 ? got_q[1] : -1);
        end
        n = rd_mem(0, 0);
        n_vec++;
        if (n[0].cnt !== '0 || n[1].cnt !== '0) begin
            n_err++;
            $display("FAIL b2b_root: got cnt0 %0d cnt1 %0d want 0 0", n[0].cnt, n[1].cnt);
        end
    endtask

    task automatic test_random();
        int mq [$];
        int v, g0, u0, exp_v;
        bit ok;
        mem.delete();
        got_q.delete();
        for (int op = 0; op < 160; op++) begin
            if (mq.size() < 60 && $urandom_range(0, 99) < 55) begin
                v = int'($urandom_range(0, 500));
                push_tree(v);
                mq.push_back(v);
            end else begin
                g0 = got_q.size();
                u0 = uf_cnt;
                do_pop(ok);
                n_vec++;
                if (!ok) begin
                    n_err++;
                    $display("FAIL rand_timeout: op %0d ready never seen", op);
                end else if (mq.size() == 0) begin
                    if (uf_cnt != u0 + 1 || got_q.size() != g0) begin
                        n_err++;
                        $display("FAIL rand_uflow: op %0d got %0d uflow %0d valid want 1 and 0",
                                 op, uf_cnt - u0, got_q.size() - g0);
                    end
                end else begin
                    mq.sort();
                    exp_v = mq.pop_front();
                    if (got_q.size() != g0 + 1 || got_q[g0] != exp_v) begin
                        n_err++;
                        $display("FAIL rand_pop: op %0d got %0d want %0d", op,
                                 got_q.size() > g0 ? got_q[g0] : -1, exp_v);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midwalk();
        node_t n;
        bit    ok;
        build_chain();
        wait_ready(ok);
        i_pop = 1'b1;
        tick();
        i_pop = 1'b0;
        tick(2);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ready, pop_valid, pop_uflow, wr, rd} !== 5'b10000) begin
            n_err++;
            $display("FAIL midreset_ctrl: got %b want 10000", {ready, pop_valid, pop_uflow, wr, rd});
        end
        n_vec++;
        if ({rlvl, wlvl, raddr, waddr} !== '0 || pop_data !== '1) begin
            n_err++;
            $display("FAIL midreset_out: got addr %h data %h want 0 and ffff", {rlvl, wlvl, raddr, waddr}, pop_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        mem.delete();
        got_q.delete();
        n = empty_node();
        n[3].cnt = CTW'(1);
        n[3].val = VW'(42);
        mem[key(0, 0)] = n;
        do_pop(ok);
        n_vec++;
        if (!ok || got_q.size() != 1 || got_q[0] != 42) begin
            n_err++;
            $display("FAIL midreset_recover: got %0d pops first %0d want 1 pop of 42", got_q.size(),
                     got_q.size() > 0 ? got_q[0] : -1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_refill();
        test_underflow();
        test_full_depth();
        test_back_to_back();
        test_random();
        test_reset_midwalk();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
